// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the control pipeline.
// Holds the control bundle widths, the bit positions inside each bundle,
// the packed bundle types carried through the stage registers, and the
// main-decoder opcode values the bundles are derived from.
package ctrl_pkg;

    localparam int WB_W  = 2;
    localparam int M_W   = 3;
    localparam int EXE_W = 4;

    // WB bundle bit positions
    localparam int WB_REGWRITE  = 0;
    localparam int WB_MEMTOREG  = 1;
    // M bundle bit positions
    localparam int M_BRANCH     = 0;
    localparam int M_MEMREAD    = 1;
    localparam int M_MEMWRITE   = 2;
    // EXE bundle bit positions
    localparam int EXE_REGDST   = 0;
    localparam int EXE_ALUOP_LO = 1;
    localparam int EXE_ALUOP_HI = 2;
    localparam int EXE_ALUSRC   = 3;

    typedef logic [WB_W-1:0]  wb_t;
    typedef logic [M_W-1:0]   m_t;
    typedef logic [EXE_W-1:0] exe_t;

    // Full control word as decoded in ID and held in ID/EX
    typedef struct packed {
        wb_t  wb;
        m_t   m;
        exe_t exe;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_NOP = '{wb: 2'b00, m: 3'b000, exe: 4'b0000};

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;

endpackage

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: signal bundle between the ID-stage decoder / EX-MEM-WB
// datapath and the control pipeline.
//   master : decoder/datapath side; drives id_* and mem_zero, receives
//            per-stage control, destinations, stall and pc_src.
//   slave  : control pipeline side (ctrl_pipe).
interface ctrl_pipe_if
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5
);
    logic              id_valid;
    wb_t               id_wb;
    m_t                id_m;
    exe_t              id_exe;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              mem_zero;

    exe_t              ex_exe;
    m_t                ex_m;
    wb_t               ex_wb;
    logic [REG_AW-1:0] ex_rt;
    m_t                mem_m;
    wb_t               mem_wb;
    logic [REG_AW-1:0] mem_dst;
    wb_t               wb_wb;
    logic [REG_AW-1:0] wb_dst;
    logic              stall;
    logic              pc_src;

    modport master (
        output id_valid, id_wb, id_m, id_exe, id_rs, id_rt, id_rd, mem_zero,
        input  ex_exe, ex_m, ex_wb, ex_rt, mem_m, mem_wb, mem_dst,
               wb_wb, wb_dst, stall, pc_src
    );

    modport slave (
        input  id_valid, id_wb, id_m, id_exe, id_rs, id_rt, id_rd, mem_zero,
        output ex_exe, ex_m, ex_wb, ex_rt, mem_m, mem_wb, mem_dst,
               wb_wb, wb_dst, stall, pc_src
    );
endinterface

// File: rtl/ctrl_pipe_hazard_unit.sv
// hazard_unit: combinational load-use detection and branch resolution.
// Ports:
//   id_valid, id_rs, id_rt : instruction currently in ID
//   ex_mem_read, ex_rt     : load flag and target of the instruction in EX
//   mem_branch, mem_zero   : branch flag in MEM and its registered ALU zero
//   stall                  : hold PC and IF/ID, bubble into ID/EX
//   pc_src                 : branch taken; squash younger stages
module hazard_unit
    import ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 0
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              mem_branch,
    input  logic              mem_zero,
    output logic              stall,
    output logic              pc_src
);
    localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

    // Branch in MEM overrides the hazard: the dependent instruction in ID is
    // about to be flushed, so stalling for it would only waste a cycle.
    always_comb begin
        pc_src = 1'b0;
        stall  = 1'b0;
        pc_src = mem_branch & mem_zero;
        stall  = id_valid & ex_mem_read & (ex_rt != ZERO_IDX)
               & ((ex_rt == id_rs) | (ex_rt == id_rt)) & ~pc_src;
    end
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded control bundles and destination indices through
// the ID/EX, EX/MEM and MEM/WB registers, inserts load-use bubbles and
// squashes younger control on a taken branch resolved in MEM.
// Ports:
//   clk, reset : pipeline clock, asynchronous active-high reset
//   bus        : ctrl_pipe_if.slave (ID inputs, mem_zero, stage outputs,
//                stall, pc_src)
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 0
) (
    input  logic         clk,
    input  logic         reset,
    ctrl_pipe_if.slave   bus
);
    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};

    // ID/EX
    ctrl_bundle_t      ex_ctrl_r;
    logic [REG_AW-1:0] ex_rt_r;
    logic [REG_AW-1:0] ex_rd_r;
    // EX/MEM
    m_t                mem_m_r;
    wb_t               mem_wb_r;
    logic [REG_AW-1:0] mem_dst_r;
    // MEM/WB
    wb_t               wb_wb_r;
    logic [REG_AW-1:0] wb_dst_r;

    logic              stall_s;
    logic              pc_src_s;
    logic              id_load_s;
    logic [REG_AW-1:0] ex_dst_s;
    ctrl_bundle_t      id_ctrl_s;

    hazard_unit #(
        .REG_AW   (REG_AW),
        .ZERO_REG (ZERO_REG)
    ) u_hazard (
        .id_valid    (bus.id_valid),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .ex_mem_read (ex_ctrl_r.m[M_MEMREAD]),
        .ex_rt       (ex_rt_r),
        .mem_branch  (mem_m_r[M_BRANCH]),
        .mem_zero    (bus.mem_zero),
        .stall       (stall_s),
        .pc_src      (pc_src_s)
    );

    // ID/EX load decision and EX destination select
    always_comb begin
        id_ctrl_s = CTRL_NOP;
        id_load_s = 1'b0;
        ex_dst_s  = REG_ZERO;
        id_ctrl_s = '{wb: bus.id_wb, m: bus.id_m, exe: bus.id_exe};
        // Squash, bubble and empty ID all collapse to loading a NOP
        if (bus.id_valid && !stall_s && !pc_src_s) begin
            id_load_s = 1'b1;
        end else begin
            id_load_s = 1'b0;
        end
        if (ex_ctrl_r.exe[EXE_REGDST]) begin
            ex_dst_s = ex_rd_r;
        end else begin
            ex_dst_s = ex_rt_r;
        end
    end

    // ID/EX register; register indices are cleared with the control so a
    // bubble shows as all-zero on the EX outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ctrl_r <= CTRL_NOP;
            ex_rt_r   <= REG_ZERO;
            ex_rd_r   <= REG_ZERO;
        end else if (id_load_s) begin
            ex_ctrl_r <= id_ctrl_s;
            ex_rt_r   <= bus.id_rt;
            ex_rd_r   <= bus.id_rd;
        end else begin
            ex_ctrl_r <= CTRL_NOP;
            ex_rt_r   <= REG_ZERO;
            ex_rd_r   <= REG_ZERO;
        end
    end

    // EX/MEM register; a taken branch kills the instruction behind it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_m_r   <= 3'b000;
            mem_wb_r  <= 2'b00;
            mem_dst_r <= REG_ZERO;
        end else if (pc_src_s) begin
            mem_m_r   <= 3'b000;
            mem_wb_r  <= 2'b00;
            mem_dst_r <= REG_ZERO;
        end else begin
            mem_m_r   <= ex_ctrl_r.m;
            mem_wb_r  <= ex_ctrl_r.wb;
            mem_dst_r <= ex_dst_s;
        end
    end

    // MEM/WB register; the branch itself carries wb=0 so it never writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_wb_r  <= 2'b00;
            wb_dst_r <= REG_ZERO;
        end else begin
            wb_wb_r  <= mem_wb_r;
            wb_dst_r <= mem_dst_r;
        end
    end

    assign bus.ex_exe  = ex_ctrl_r.exe;
    assign bus.ex_m    = ex_ctrl_r.m;
    assign bus.ex_wb   = ex_ctrl_r.wb;
    assign bus.ex_rt   = ex_rt_r;
    assign bus.mem_m   = mem_m_r;
    assign bus.mem_wb  = mem_wb_r;
    assign bus.mem_dst = mem_dst_r;
    assign bus.wb_wb   = wb_wb_r;
    assign bus.wb_dst  = wb_dst_r;
    assign bus.stall   = stall_s;
    assign bus.pc_src  = pc_src_s;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: self-checking bench for ctrl_pipe. Directed vector table for
// the straight-line, load-use, zero-register and branch sequences, a
// mid-run asynchronous reset, then random traffic against an
// instruction-level pipeline model.
module tb_ctrl_pipe;

    typedef struct packed {
        logic       v;
        logic [1:0] wb;
        logic [2:0] m;
        logic [3:0] exe;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       mz;
    } in_t;

    typedef struct packed {
        logic [3:0] ex_exe;
        logic [2:0] ex_m;
        logic [1:0] ex_wb;
        logic [4:0] ex_rt;
        logic [2:0] mem_m;
        logic [1:0] mem_wb;
        logic [4:0] mem_dst;
        logic [1:0] wb_wb;
        logic [4:0] wb_dst;
        logic       stall;
        logic       pc_src;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } tv_t;

    // one in-flight instruction as seen by the model
    typedef struct packed {
        logic [1:0] wb;
        logic [2:0] m;
        logic [3:0] exe;
        logic [4:0] rt;
        logic [4:0] rd;
    } instr_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    ctrl_pipe_if #(.REG_AW(5)) bus ();

    ctrl_pipe #(.REG_AW(5), .ZERO_REG(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t ii(logic v, logic [1:0] wb, logic [2:0] m, logic [3:0] exe,
                               logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic mz);
        in_t x;
        x = '{v: v, wb: wb, m: m, exe: exe, rs: rs, rt: rt, rd: rd, mz: mz};
        return x;
    endfunction

    function automatic out_t oo(logic [3:0] ee, logic [2:0] em, logic [1:0] ew, logic [4:0] ert,
                                logic [2:0] mm, logic [1:0] mw, logic [4:0] md,
                                logic [1:0] ww, logic [4:0] wd, logic st, logic pc);
        out_t o;
        o = '{ex_exe: ee, ex_m: em, ex_wb: ew, ex_rt: ert, mem_m: mm, mem_wb: mw,
              mem_dst: md, wb_wb: ww, wb_dst: wd, stall: st, pc_src: pc};
        return o;
    endfunction

    function automatic out_t get_out();
        return oo(bus.ex_exe, bus.ex_m, bus.ex_wb, bus.ex_rt, bus.mem_m, bus.mem_wb,
                  bus.mem_dst, bus.wb_wb, bus.wb_dst, bus.stall, bus.pc_src);
    endfunction

    task automatic drive(input in_t x);
        bus.id_valid = x.v;
        bus.id_wb    = x.wb;
        bus.id_m     = x.m;
        bus.id_exe   = x.exe;
        bus.id_rs    = x.rs;
        bus.id_rt    = x.rt;
        bus.id_rd    = x.rd;
        bus.mem_zero = x.mz;
    endtask

    // drive after the falling edge, sample 1 time unit later
    task automatic step(input in_t x);
        @(negedge clk);
        drive(x);
        #1;
    endtask

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = get_out();
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    instr_t pipe[3];  // 0 = EX, 1 = MEM, 2 = WB

    function automatic logic [4:0] dest(instr_t x);
        return x.exe[0] ? x.rd : x.rt;
    endfunction

    function automatic logic m_pc(in_t x);
        return pipe[1].m[0] & x.mz;
    endfunction

    function automatic logic m_stall(in_t x);
        logic hit;
        hit = (pipe[0].rt != 5'd0) && (pipe[0].rt == x.rs || pipe[0].rt == x.rt);
        return x.v & pipe[0].m[1] & hit & ~m_pc(x);
    endfunction

    function automatic out_t m_out(in_t x);
        return oo(pipe[0].exe, pipe[0].m, pipe[0].wb, pipe[0].rt,
                  pipe[1].m, pipe[1].wb, dest(pipe[1]),
                  pipe[2].wb, dest(pipe[2]), m_stall(x), m_pc(x));
    endfunction

    task automatic m_advance(input in_t x);
        instr_t nop;
        instr_t incoming;
        logic   pc;
        logic   st;
        nop = '{wb: 2'b00, m: 3'b000, exe: 4'b0000, rt: 5'd0, rd: 5'd0};
        pc  = m_pc(x);
        st  = m_stall(x);
        incoming = '{wb: x.wb, m: x.m, exe: x.exe, rt: x.rt, rd: x.rd};
        pipe[2] = pipe[1];
        pipe[1] = pc ? nop : pipe[0];
        pipe[0] = (pc || st || !x.v) ? nop : incoming;
    endtask

    tv_t  tv[29];
    in_t  IDLE, R9, LW8, ADD8, LW0, ADD0, BEQ, LW5, ADD5T, ADD5N, cur;
    out_t Z;

    initial begin
        total = 0;
        bad   = 0;
        IDLE  = ii(1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 5'd0, 1'b0);
        R9    = ii(1'b1, 2'b01, 3'b000, 4'b0001, 5'd1, 5'd2, 5'd9, 1'b0);
        LW8   = ii(1'b1, 2'b11, 3'b010, 4'b1000, 5'd1, 5'd8, 5'd0, 1'b0);
        ADD8  = ii(1'b1, 2'b01, 3'b000, 4'b0001, 5'd8, 5'd3, 5'd10, 1'b0);
        LW0   = ii(1'b1, 2'b11, 3'b010, 4'b1000, 5'd1, 5'd0, 5'd0, 1'b0);
        ADD0  = ii(1'b1, 2'b01, 3'b000, 4'b0001, 5'd0, 5'd0, 5'd11, 1'b0);
        BEQ   = ii(1'b1, 2'b00, 3'b001, 4'b0010, 5'd1, 5'd2, 5'd0, 1'b0);
        LW5   = ii(1'b1, 2'b11, 3'b010, 4'b1000, 5'd1, 5'd5, 5'd0, 1'b0);
        ADD5T = ii(1'b1, 2'b01, 3'b000, 4'b0001, 5'd5, 5'd6, 5'd12, 1'b1);
        ADD5N = ii(1'b1, 2'b01, 3'b000, 4'b0001, 5'd5, 5'd6, 5'd12, 1'b0);
        Z     = oo(4'd0, 3'd0, 2'd0, 5'd0, 3'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 1'b0);

        // straight-line R-type
        tv[0]  = '{R9,   Z};
        tv[1]  = '{IDLE, oo(4'b0001, 3'b000, 2'b01, 5'd2, 3'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 1'b0)};
        tv[2]  = '{IDLE, oo(4'd0, 3'd0, 2'd0, 5'd0, 3'b000, 2'b01, 5'd9, 2'd0, 5'd0, 1'b0, 1'b0)};
        tv[3]  = '{IDLE, oo(4'd0, 3'd0, 2'd0, 5'd0, 3'd0, 2'd0, 5'd0, 2'b01, 5'd9, 1'b0, 1'b0)};
        tv[4]  = '{IDLE, Z};
        // load-use: one-cycle stall, bubble, then the add follows
        tv[5]  = '{LW8,  Z};
        tv[6]  = '{ADD8, oo(4'b1000, 3'b010, 2'b11, 5'd8, 3'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b1, 1'b0)};
        tv[7]  = '{ADD8, oo(4'd0, 3'd0, 2'd0, 5'd0, 3'b010, 2'b11, 5'd8, 2'd0, 5'd0, 1'b0, 1'b0)};
        tv[8]  = '{IDLE, oo(4'b0001, 3'b000, 2'b01, 5'd3, 3'd0, 2'd0, 5'd0, 2'b11, 5'd8, 1'b0, 1'b0)};
        tv[9]  = '{IDLE, oo(4'd0, 3'd0, 2'd0, 5'd0, 3'b000, 2'b01, 5'd10, 2'd0, 5'd0, 1'b0, 1'b0)};
        tv[10] = '{IDLE, oo(4'd0, 3'd0, 2'd0, 5'd0, 3'd0, 2'd0, 5'd0, 2'b01, 5'd10, 1'b0, 1'b0)};
        // zero register never stalls
        tv[11] = '{LW0,  Z};
        tv[12] = '{ADD0, oo(4'b1000, 3'b010, 2'b11, 5'd0, 3'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 1'b0)};
        tv[13] = '{IDLE, oo(4'b0001, 3'b000, 2'b01, 5'd0, 3'b010, 2'b11, 5'd0, 2'd0, 5'd0, 1'b0, 1'b0)};
        tv[14] = '{IDLE, oo(4'd0, 3'd0, 2'd0, 5'd0, 3'b000, 2'b01, 5'd11, 2'b11, 5'd0, 1'b0, 1'b0)};
        tv[15] = '{IDLE, oo(4'd0, 3'd0, 2'd0, 5'd0, 3'd0, 2'd0, 5'd0, 2'b01, 5'd11, 1'b0, 1'b0)};
        tv[16] = '{IDLE, Z};
        // taken branch with a load-use pending behind it
        tv[17] = '{BEQ,   Z};
        tv[18] = '{LW5,   oo(4'b0010, 3'b001, 2'b00, 5'd2, 3'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 1'b0)};
        tv[19] = '{ADD5T, oo(4'b1000, 3'b010, 2'b11, 5'd5, 3'b001, 2'b00, 5'd2, 2'd0, 5'd0, 1'b0, 1'b1)};
        tv[20] = '{IDLE,  oo(4'd0, 3'd0, 2'd0, 5'd0, 3'd0, 2'd0, 5'd0, 2'b00, 5'd2, 1'b0, 1'b0)};
        tv[21] = '{IDLE,  Z};
        // not-taken branch: younger instructions proceed, stall happens
        tv[22] = '{BEQ,   Z};
        tv[23] = '{LW5,   oo(4'b0010, 3'b001, 2'b00, 5'd2, 3'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 1'b0)};
        tv[24] = '{ADD5N, oo(4'b1000, 3'b010, 2'b11, 5'd5, 3'b001, 2'b00, 5'd2, 2'd0, 5'd0, 1'b1, 1'b0)};
        tv[25] = '{ADD5N, oo(4'd0, 3'd0, 2'd0, 5'd0, 3'b010, 2'b11, 5'd5, 2'b00, 5'd2, 1'b0, 1'b0)};
        tv[26] = '{IDLE,  oo(4'b0001, 3'b000, 2'b01, 5'd6, 3'd0, 2'd0, 5'd0, 2'b11, 5'd5, 1'b0, 1'b0)};
        tv[27] = '{IDLE,  oo(4'd0, 3'd0, 2'd0, 5'd0, 3'b000, 2'b01, 5'd12, 2'd0, 5'd0, 1'b0, 1'b0)};
        tv[28] = '{IDLE,  oo(4'd0, 3'd0, 2'd0, 5'd0, 3'd0, 2'd0, 5'd0, 2'b01, 5'd12, 1'b0, 1'b0)};

        // reset state
        reset = 1'b1;
        drive(IDLE);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", Z);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 29; k++) begin
            step(tv[k].i);
            check($sformatf("vec%0d", k), tv[k].o);
        end

        // fill every stage with a pending taken branch, then reset between edges
        step(R9);
        step(BEQ);
        step(LW5);
        step(ADD5T);
        check("prefill", oo(4'b1000, 3'b010, 2'b11, 5'd5, 3'b001, 2'b00, 5'd2,
                            2'b01, 5'd9, 1'b0, 1'b1));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", Z);
        drive(IDLE);
        @(negedge clk);
        reset = 1'b0;
        step(IDLE);
        check("after_reset", Z);

        // random traffic against the model
        for (int j = 0; j < 3; j++) pipe[j] = '{wb: 2'b00, m: 3'b000, exe: 4'b0000, rt: 5'd0, rd: 5'd0};
        cur = IDLE;
        for (int n = 0; n < 400; n++) begin
            if (!(cur.v && m_stall(cur))) begin
                cur.v   = ($urandom_range(0, 3) != 0);
                cur.wb  = 2'($urandom_range(0, 3));
                cur.m   = 3'($urandom_range(0, 7));
                cur.exe = 4'($urandom_range(0, 15));
                cur.rs  = 5'($urandom_range(0, 3));
                cur.rt  = 5'($urandom_range(0, 3));
                cur.rd  = 5'($urandom_range(0, 3));
            end
            cur.mz = 1'($urandom_range(0, 1));
            step(cur);
            check($sformatf("rand%0d", n), m_out(cur));
            m_advance(cur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
